// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
//
// Pipeline register between Instruction Decode and Execute of the 5-stage
// ARM core. Captures the decoded control bits, operand values, shifter
// operand, branch offset and register addresses, and presents them to EX.
//
// Update priority on each rising clk edge: rst > flush > freeze > load.
//   rst    : asynchronous, active-high; clears every output immediately
//   flush  : loads an all-zero bubble (overrides freeze)
//   freeze : holds every output unchanged
//   load   : every output takes its *_in value; mem_cmd = mem_r_en_in | mem_w_en_in
//
// Ports:
//   clk, rst, freeze, flush                  - clock / reset / pipeline control
//   valid_in        -> valid          (1)    - slot holds a real instruction
//   pc_in           -> pc             (32)   - PC+4 of the instruction
//   wb_en_in        -> wb_en          (1)    - register write-back enable
//   mem_r_en_in     -> mem_r_en       (1)    - load
//   mem_w_en_in     -> mem_w_en       (1)    - store
//                      mem_cmd        (1)    - load or store (memory-offset operand 2)
//   exe_cmd_in      -> exe_cmd        (4)    - ALU operation code
//   b_in            -> b              (1)    - branch
//   s_in            -> s              (1)    - update status flags
//   imm_in          -> imm            (1)    - operand 2 is a rotated immediate
//   val_rn_in       -> val_rn         (32)   - Rn value
//   val_rm_in       -> val_rm         (32)   - Rm value
//   shift_operand_in-> shift_operand  (12)   - instr[11:0]
//   signed_imm24_in -> signed_imm24   (24)   - branch offset
//   dest_in         -> dest           (4)    - destination register
//   src1_in         -> src1           (4)    - Rn address (forwarding)
//   src2_in         -> src2           (4)    - Rm/Rd address (forwarding)
//   sr_in           -> sr             (4)    - {N,Z,C,V} at decode
// ---------------------------------------------------------------------------
module id_ex_stage_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        flush,
    input  logic        valid_in,
    input  logic [31:0] pc_in,
    input  logic        wb_en_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic [3:0]  exe_cmd_in,
    input  logic        b_in,
    input  logic        s_in,
    input  logic        imm_in,
    input  logic [31:0] val_rn_in,
    input  logic [31:0] val_rm_in,
    input  logic [11:0] shift_operand_in,
    input  logic [23:0] signed_imm24_in,
    input  logic [3:0]  dest_in,
    input  logic [3:0]  src1_in,
    input  logic [3:0]  src2_in,
    input  logic [3:0]  sr_in,
    output logic        valid,
    output logic [31:0] pc,
    output logic        wb_en,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic        mem_cmd,
    output logic [3:0]  exe_cmd,
    output logic        b,
    output logic        s,
    output logic        imm,
    output logic [31:0] val_rn,
    output logic [31:0] val_rm,
    output logic [11:0] shift_operand,
    output logic [23:0] signed_imm24,
    output logic [3:0]  dest,
    output logic [3:0]  src1,
    output logic [3:0]  src2,
    output logic [3:0]  sr
);

    // One packed record so flush, freeze and reset act on every field at once;
    // a partial update of the slot is impossible by construction.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        mem_cmd;
        logic [3:0]  exe_cmd;
        logic        b;
        logic        s;
        logic        imm;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm24;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [3:0]  sr;
    } stage_t;

    localparam int     STAGE_W = $bits(stage_t);
    // Bubble: control and data fields all zero so waveforms stay deterministic.
    localparam stage_t BUBBLE  = {STAGE_W{1'b0}};

    stage_t stage_d;
    stage_t stage_q;

    // Next-state selection: flush beats freeze, freeze beats load.
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = BUBBLE;
        end else if (freeze) begin
            stage_d = stage_q;
        end else begin
            stage_d.valid         = valid_in;
            stage_d.pc            = pc_in;
            stage_d.wb_en         = wb_en_in;
            stage_d.mem_r_en      = mem_r_en_in;
            stage_d.mem_w_en      = mem_w_en_in;
            // Pre-decoded here so EX sees a registered select with no OR in its path.
            stage_d.mem_cmd       = mem_r_en_in | mem_w_en_in;
            stage_d.exe_cmd       = exe_cmd_in;
            stage_d.b             = b_in;
            stage_d.s             = s_in;
            stage_d.imm           = imm_in;
            stage_d.val_rn        = val_rn_in;
            stage_d.val_rm        = val_rm_in;
            stage_d.shift_operand = shift_operand_in;
            stage_d.signed_imm24  = signed_imm24_in;
            stage_d.dest          = dest_in;
            stage_d.src1          = src1_in;
            stage_d.src2          = src2_in;
            stage_d.sr            = sr_in;
        end
    end

    // Stage register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= BUBBLE;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign valid         = stage_q.valid;
    assign pc            = stage_q.pc;
    assign wb_en         = stage_q.wb_en;
    assign mem_r_en      = stage_q.mem_r_en;
    assign mem_w_en      = stage_q.mem_w_en;
    assign mem_cmd       = stage_q.mem_cmd;
    assign exe_cmd       = stage_q.exe_cmd;
    assign b             = stage_q.b;
    assign s             = stage_q.s;
    assign imm           = stage_q.imm;
    assign val_rn        = stage_q.val_rn;
    assign val_rm        = stage_q.val_rm;
    assign shift_operand = stage_q.shift_operand;
    assign signed_imm24  = stage_q.signed_imm24;
    assign dest          = stage_q.dest;
    assign src1          = stage_q.src1;
    assign src2          = stage_q.src2;
    assign sr            = stage_q.sr;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage_reg
//
// Self-checking bench for id_ex_stage_reg: directed scenarios followed by a
// randomized run with random freeze/flush and asynchronous reset pulses,
// all compared against a reference model of the ID/EX slot.
// ---------------------------------------------------------------------------
module tb_id_ex_stage_reg;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        flush;
    logic        valid_in;
    logic [31:0] pc_in;
    logic        wb_en_in;
    logic        mem_r_en_in;
    logic        mem_w_en_in;
    logic [3:0]  exe_cmd_in;
    logic        b_in;
    logic        s_in;
    logic        imm_in;
    logic [31:0] val_rn_in;
    logic [31:0] val_rm_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm24_in;
    logic [3:0]  dest_in;
    logic [3:0]  src1_in;
    logic [3:0]  src2_in;
    logic [3:0]  sr_in;

    logic        valid;
    logic [31:0] pc;
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        mem_cmd;
    logic [3:0]  exe_cmd;
    logic        b;
    logic        s;
    logic        imm;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm24;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  sr;

    id_ex_stage_reg dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .valid_in(valid_in), .pc_in(pc_in), .wb_en_in(wb_en_in),
        .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .exe_cmd_in(exe_cmd_in), .b_in(b_in), .s_in(s_in), .imm_in(imm_in),
        .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
        .shift_operand_in(shift_operand_in), .signed_imm24_in(signed_imm24_in),
        .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .sr_in(sr_in),
        .valid(valid), .pc(pc), .wb_en(wb_en), .mem_r_en(mem_r_en),
        .mem_w_en(mem_w_en), .mem_cmd(mem_cmd), .exe_cmd(exe_cmd), .b(b),
        .s(s), .imm(imm), .val_rn(val_rn), .val_rm(val_rm),
        .shift_operand(shift_operand), .signed_imm24(signed_imm24),
        .dest(dest), .src1(src1), .src2(src2), .sr(sr)
    );

    // 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the instruction currently presented to EX.
    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        wb_en, mem_r_en, mem_w_en, mem_cmd;
        logic [3:0]  exe_cmd;
        logic        b, s, imm;
        logic [31:0] val_rn, val_rm;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm24;
        logic [3:0]  dest, src1, src2, sr;
    } slot_t;

    slot_t model;
    int    n_vec = 0;
    int    n_err = 0;

    function automatic slot_t empty_slot();
        slot_t e;
        e.valid = 1'b0; e.pc = 32'd0; e.wb_en = 1'b0; e.mem_r_en = 1'b0;
        e.mem_w_en = 1'b0; e.mem_cmd = 1'b0; e.exe_cmd = 4'd0; e.b = 1'b0;
        e.s = 1'b0; e.imm = 1'b0; e.val_rn = 32'd0; e.val_rm = 32'd0;
        e.shift_operand = 12'd0; e.signed_imm24 = 24'd0; e.dest = 4'd0;
        e.src1 = 4'd0; e.src2 = 4'd0; e.sr = 4'd0;
        return e;
    endfunction

    // What ID is offering right now; mem_cmd means "this is a memory access".
    function automatic slot_t offered_slot();
        slot_t e;
        e.valid = valid_in; e.pc = pc_in; e.wb_en = wb_en_in;
        e.mem_r_en = mem_r_en_in; e.mem_w_en = mem_w_en_in;
        e.mem_cmd = (mem_r_en_in == 1'b1 || mem_w_en_in == 1'b1) ? 1'b1 : 1'b0;
        e.exe_cmd = exe_cmd_in; e.b = b_in; e.s = s_in; e.imm = imm_in;
        e.val_rn = val_rn_in; e.val_rm = val_rm_in;
        e.shift_operand = shift_operand_in; e.signed_imm24 = signed_imm24_in;
        e.dest = dest_in; e.src1 = src1_in; e.src2 = src2_in; e.sr = sr_in;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string ph);
        check({ph, ".valid"},         32'(valid),         32'(model.valid));
        check({ph, ".pc"},            pc,                 model.pc);
        check({ph, ".wb_en"},         32'(wb_en),         32'(model.wb_en));
        check({ph, ".mem_r_en"},      32'(mem_r_en),      32'(model.mem_r_en));
        check({ph, ".mem_w_en"},      32'(mem_w_en),      32'(model.mem_w_en));
        check({ph, ".mem_cmd"},       32'(mem_cmd),       32'(model.mem_cmd));
        check({ph, ".exe_cmd"},       32'(exe_cmd),       32'(model.exe_cmd));
        check({ph, ".b"},             32'(b),             32'(model.b));
        check({ph, ".s"},             32'(s),             32'(model.s));
        check({ph, ".imm"},           32'(imm),           32'(model.imm));
        check({ph, ".val_rn"},        val_rn,             model.val_rn);
        check({ph, ".val_rm"},        val_rm,             model.val_rm);
        check({ph, ".shift_operand"}, 32'(shift_operand), 32'(model.shift_operand));
        check({ph, ".signed_imm24"},  32'(signed_imm24),  32'(model.signed_imm24));
        check({ph, ".dest"},          32'(dest),          32'(model.dest));
        check({ph, ".src1"},          32'(src1),          32'(model.src1));
        check({ph, ".src2"},          32'(src2),          32'(model.src2));
        check({ph, ".sr"},            32'(sr),            32'(model.sr));
    endtask

    task automatic randomize_inputs();
        valid_in = 1'($urandom()); pc_in = $urandom(); wb_en_in = 1'($urandom());
        mem_r_en_in = 1'($urandom()); mem_w_en_in = 1'($urandom());
        exe_cmd_in = 4'($urandom()); b_in = 1'($urandom()); s_in = 1'($urandom());
        imm_in = 1'($urandom()); val_rn_in = $urandom(); val_rm_in = $urandom();
        shift_operand_in = 12'($urandom()); signed_imm24_in = 24'($urandom());
        dest_in = 4'($urandom()); src1_in = 4'($urandom());
        src2_in = 4'($urandom()); sr_in = 4'($urandom());
    endtask

    // One clock: advance the model at the edge, compare on the falling edge.
    task automatic tick(input string ph);
        @(posedge clk);
        if (rst) model = empty_slot();
        else if (flush) model = empty_slot();
        else if (freeze) model = model;
        else model = offered_slot();
        @(negedge clk);
        check_all(ph);
    endtask

    int dq[$];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model  = empty_slot();
        rst    = 1'b1;
        freeze = 1'b0;
        flush  = 1'b0;
        randomize_inputs();
        #1;
        check_all("reset_initial");
        tick("reset_held");

        // Load: plain ALU op.
        rst = 1'b0;
        randomize_inputs();
        valid_in = 1'b1; exe_cmd_in = 4'b0010; val_rm_in = 32'hF000_000F;
        shift_operand_in = 12'h0E3; imm_in = 1'b0; dest_in = 4'd3;
        mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
        tick("load");
        check("load.exe_cmd_const", 32'(exe_cmd), 32'h2);
        check("load.val_rm_const", val_rm, 32'hF000_000F);
        check("load.mem_cmd_const", 32'(mem_cmd), 32'h0);

        // Store then load.
        mem_w_en_in = 1'b1; mem_r_en_in = 1'b0; shift_operand_in = 12'h804;
        tick("store");
        check("store.mem_cmd_const", 32'(mem_cmd), 32'h1);
        mem_w_en_in = 1'b0; mem_r_en_in = 1'b1;
        tick("ldr");
        check("ldr.mem_cmd_const", 32'(mem_cmd), 32'h1);
        check("ldr.mem_r_en_const", 32'(mem_r_en), 32'h1);

        // Freeze for 3 cycles.
        mem_r_en_in = 1'b0; pc_in = 32'h10;
        tick("frz_load");
        freeze = 1'b1; pc_in = 32'h14;
        for (int i = 0; i < 3; i++) begin
            tick("frz_hold");
            check("frz_hold.pc_const", pc, 32'h10);
        end
        freeze = 1'b0;
        tick("frz_release");
        check("frz_release.pc_const", pc, 32'h14);

        // Flush overrides freeze.
        valid_in = 1'b1; wb_en_in = 1'b1;
        tick("pre_flush");
        flush = 1'b1; freeze = 1'b1;
        tick("flush_frz");
        check("flush_frz.valid_const", 32'(valid), 32'h0);
        flush = 1'b0; freeze = 1'b0; pc_in = 32'h0000_0100;
        tick("post_flush");
        check("post_flush.pc_const", pc, 32'h0000_0100);

        // Two consecutive flushes give two bubbles.
        flush = 1'b1;
        tick("flush_k1");
        tick("flush_k2");
        flush = 1'b0;

        // Back-to-back stream of 8 instructions.
        for (int i = 1; i <= 8; i++) begin
            randomize_inputs();
            dest_in = 4'(i);
            dq.push_back(i);
            tick("stream");
            check("stream.dest_order", 32'(dest), 32'(dq.pop_front()));
        end

        // Reset mid-operation, between edges.
        randomize_inputs();
        pc_in = 32'h0000_0040; wb_en_in = 1'b1; valid_in = 1'b1;
        tick("pre_rst");
        #1 rst = 1'b1;
        model = empty_slot();
        #1 check_all("rst_async");
        check("rst_async.pc_const", pc, 32'h0);
        tick("rst_held");
        rst = 1'b0;
        tick("rst_release");

        // Randomized run.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 3) begin
                #1 rst = 1'b1;
                model = empty_slot();
                #1 check_all("rnd_rst");
                rst = 1'b0;
            end
            randomize_inputs();
            freeze = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
            flush  = ($urandom_range(0, 6) == 0) ? 1'b1 : 1'b0;
            tick("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
